// File: rtl/shot_scheduler.sv
// Shot scheduler: sequences arm -> detector ready -> start pulse -> detonation -> trigger
// for a configurable number of shots, with holdoff, per-state timeouts, abort and fault latching.
module shot_scheduler #(
  parameter int CNT_W              = 32,
  parameter int SHOT_W             = 8,
  parameter int START_PULSE_CYCLES = 20000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [SHOT_W-1:0] shot_count,
  input  logic [CNT_W-1:0]  holdoff_cycles,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic              detector_ready,
  input  logic              exp_detonation,
  input  logic              exp_trigger,
  output logic              exp_start,
  output logic              busy,
  output logic [SHOT_W-1:0] shots_done,
  output logic              done,
  output logic              error,
  output logic [2:0]        error_code
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_START      = 3'd2;
  localparam logic [2:0] S_WAIT_DET   = 3'd3;
  localparam logic [2:0] S_WAIT_TRIG  = 3'd4;
  localparam logic [2:0] S_HOLDOFF    = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;
  localparam logic [2:0] S_FAULT      = 3'd7;

  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [SHOT_W-1:0] SHOT_ONE   = SHOT_W'(1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(START_PULSE_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [SHOT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]  holdoff_q, holdoff_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [SHOT_W-1:0] shots_done_q, shots_done_d;
  logic              error_q, error_d;
  logic [2:0]        error_code_q, error_code_d;
  logic              arm_prev_q, arm_prev_d;
  logic              det_prev_q, det_prev_d;
  logic              trig_prev_q, trig_prev_d;
  logic              ready_meta_q, ready_meta_d;
  logic              ready_sync_q, ready_sync_d;
  logic              det_latch_q, det_latch_d;

  logic              arm_rise, det_edge, trig_edge;
  logic              timeout_hit, holdoff_over, busy_int, fault;
  logic [2:0]        fault_code;
  logic [SHOT_W-1:0] shots_next;

  assign arm_rise     = arm & ~arm_prev_q;
  assign det_edge     = exp_detonation & ~det_prev_q;
  assign trig_edge    = exp_trigger & ~trig_prev_q;
  assign timeout_hit  = (timeout_q != '0) && (timer_q == timeout_q - CNT_ONE);
  assign holdoff_over = (holdoff_q == '0) || (timer_q >= holdoff_q - CNT_ONE);
  assign shots_next   = shots_done_q + SHOT_ONE;
  assign busy_int     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAULT);

  assign exp_start  = (state_q == S_START);
  assign busy       = busy_int;
  assign done       = (state_q == S_DONE);
  assign shots_done = shots_done_q;
  assign error      = error_q;
  assign error_code = error_code_q;

  always_comb begin
    ready_meta_d = detector_ready;
    ready_sync_d = ready_meta_q;
    arm_prev_d   = arm;
    det_prev_d   = exp_detonation;
    trig_prev_d  = exp_trigger;
    state_d      = state_q;
    count_d      = count_q;
    holdoff_d    = holdoff_q;
    timeout_d    = timeout_q;
    shots_done_d = shots_done_q;
    error_d      = error_q;
    error_code_d = error_code_q;
    det_latch_d  = det_latch_q;
    fault        = 1'b0;
    fault_code   = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (arm_rise && !abort) begin
          count_d      = shot_count;
          holdoff_d    = holdoff_cycles;
          timeout_d    = timeout_cycles;
          shots_done_d = '0;
          error_d      = 1'b0;
          error_code_d = 3'd0;
          state_d      = (shot_count == '0) ? S_DONE : S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (ready_sync_q) begin
          state_d     = S_START;
          det_latch_d = 1'b0;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          fault_code = 3'd1;
        end
      end
      S_START: begin
        // An early detonation is remembered so WAIT_DET can leave immediately.
        det_latch_d = det_latch_q | det_edge;
        if (timer_q == PULSE_LAST) state_d = S_WAIT_DET;
      end
      S_WAIT_DET: begin
        if (det_latch_q || det_edge) begin
          state_d     = S_WAIT_TRIG;
          det_latch_d = 1'b0;
        end else if (trig_edge) begin
          fault      = 1'b1;
          fault_code = 3'd4;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          fault_code = 3'd2;
        end
      end
      S_WAIT_TRIG: begin
        if (trig_edge) begin
          shots_done_d = shots_next;
          state_d      = (shots_next == count_q) ? S_DONE : S_HOLDOFF;
        end else if (timeout_hit) begin
          fault      = 1'b1;
          fault_code = 3'd3;
        end
      end
      S_HOLDOFF: begin
        if (holdoff_over) state_d = S_WAIT_READY;
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (!arm) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any event or timeout resolved above in the same cycle.
    if (busy_int && abort) begin
      fault        = 1'b1;
      fault_code   = 3'd5;
      shots_done_d = shots_done_q;
    end
    if (fault) begin
      state_d      = S_FAULT;
      error_d      = 1'b1;
      error_code_d = fault_code;
    end

    if (state_d != state_q) timer_d = '0;
    else if (timer_q != '1) timer_d = timer_q + CNT_ONE;
    else                    timer_d = timer_q;
  end

  // arm_prev resets high so an arm level already present at release is not taken as an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      count_q      <= '0;
      holdoff_q    <= '0;
      timeout_q    <= '0;
      shots_done_q <= '0;
      error_q      <= 1'b0;
      error_code_q <= 3'd0;
      arm_prev_q   <= 1'b1;
      det_prev_q   <= 1'b0;
      trig_prev_q  <= 1'b0;
      ready_meta_q <= 1'b0;
      ready_sync_q <= 1'b0;
      det_latch_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      holdoff_q    <= holdoff_d;
      timeout_q    <= timeout_d;
      shots_done_q <= shots_done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
      arm_prev_q   <= arm_prev_d;
      det_prev_q   <= det_prev_d;
      trig_prev_q  <= trig_prev_d;
      ready_meta_q <= ready_meta_d;
      ready_sync_q <= ready_sync_d;
      det_latch_q  <= det_latch_d;
    end
  end

endmodule

// File: tb/tb_shot_scheduler.sv
// Self-checking bench for shot_scheduler: directed scenarios plus randomized multi-shot runs
// checked against a cycle-level responder/monitor model of the experiment handshake.
module tb_shot_scheduler;

  localparam int CNT_W  = 32;
  localparam int SHOT_W = 8;
  localparam int PULSE  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [SHOT_W-1:0] shot_count = '0;
  logic [CNT_W-1:0]  holdoff_cycles = '0;
  logic [CNT_W-1:0]  timeout_cycles = '0;
  logic              detector_ready = 1'b0;
  logic              exp_detonation = 1'b0;
  logic              exp_trigger = 1'b0;
  logic              exp_start;
  logic              busy;
  logic [SHOT_W-1:0] shots_done;
  logic              done;
  logic              error;
  logic [2:0]        error_code;

  int n_cmp = 0;
  int n_fail = 0;

  shot_scheduler #(
    .CNT_W(CNT_W),
    .SHOT_W(SHOT_W),
    .START_PULSE_CYCLES(PULSE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .arm(arm),
    .abort(abort),
    .shot_count(shot_count),
    .holdoff_cycles(holdoff_cycles),
    .timeout_cycles(timeout_cycles),
    .detector_ready(detector_ready),
    .exp_detonation(exp_detonation),
    .exp_trigger(exp_trigger),
    .exp_start(exp_start),
    .busy(busy),
    .shots_done(shots_done),
    .done(done),
    .error(error),
    .error_code(error_code)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for exp_start to reach the given level; ok reports whether it did.
  task automatic wait_start(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (exp_start === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    reset = 1'b0;
    arm = 1'b1;
    detector_ready = 1'b1;
    repeat (3) tick();
    outs = {exp_start, busy, done, error, error_code, shots_done};
    n_cmp++;
    if (outs !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL arm_high_at_release: busy got %b expected 0", busy);
    end
    shot_count = 8'd1;
    holdoff_cycles = '0;
    timeout_cycles = '0;
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fresh_arm_after_reset: busy got %b expected 1", busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    repeat (2) tick();
  endtask

  // One complete run with a responsive experiment model. mode: 0 late detonation,
  // 1 detonation during the start pulse, 2 random per shot.
  task automatic run_scenario(input int sc, input int ho, input int to, input int mode);
    int  det_at, trig_at, pulses, plen, gap, done_cnt, post, hexp;
    bit  gap_active, early, finished, prev_start;
    logic [SHOT_W-1:0] prev_shots;
    det_at = -1;
    trig_at = -1;
    pulses = 0;
    plen = 0;
    gap = 0;
    done_cnt = 0;
    post = -1;
    gap_active = 1'b0;
    early = 1'b0;
    finished = 1'b0;
    hexp = (ho == 0) ? 1 : ho;
    shot_count = SHOT_W'(sc);
    holdoff_cycles = CNT_W'(ho);
    timeout_cycles = CNT_W'(to);
    detector_ready = 1'b1;
    exp_detonation = 1'b0;
    exp_trigger = 1'b0;
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    n_cmp++;
    if ({busy, error, shots_done} !== {1'b1, 1'b0, SHOT_W'(0)}) begin
      n_fail++;
      $display("[TB] FAIL run_start: busy/error/shots got %b/%b/%0d expected 1/0/0", busy, error, shots_done);
    end
    prev_start = exp_start;
    prev_shots = shots_done;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (cyc > 0) tick();
      if (exp_start && !prev_start) begin
        if (gap_active) begin
          n_cmp++;
          if (gap !== hexp + 1) begin
            n_fail++;
            $display("[TB] FAIL holdoff_gap: got %0d cycles expected %0d", gap, hexp + 1);
          end
        end
        gap_active = 1'b0;
        plen = 0;
        early = (mode == 2) ? bit'($urandom_range(0, 1)) : (mode == 1);
        if (early) det_at = cyc + int'($urandom_range(0, PULSE - 1));
      end
      if (exp_start) plen++;
      if (!exp_start && prev_start) begin
        n_cmp++;
        if (plen !== PULSE) begin
          n_fail++;
          $display("[TB] FAIL pulse_len: got %0d expected %0d", plen, PULSE);
        end
        pulses++;
        if (early) trig_at = cyc + int'($urandom_range(1, 4));
        else begin
          det_at = cyc + int'($urandom_range(0, 4));
          trig_at = det_at + int'($urandom_range(1, 4));
        end
      end
      if (shots_done !== prev_shots) begin
        n_cmp++;
        if (shots_done !== prev_shots + SHOT_W'(1)) begin
          n_fail++;
          $display("[TB] FAIL shot_increment: got %0d expected %0d", shots_done, prev_shots + SHOT_W'(1));
        end
        if (int'(shots_done) != sc) begin
          gap_active = 1'b1;
          gap = 0;
        end
      end
      if (gap_active && !exp_start) gap++;
      if (done) begin
        done_cnt++;
        if (post < 0) post = 3;
      end
      if (post == 0 || error) finished = 1'b1;
      if (post > 0) post--;
      if (cyc == det_at) exp_detonation = 1'b1;
      if (cyc == trig_at) begin
        exp_trigger = 1'b1;
        exp_detonation = 1'b0;
      end else exp_trigger = 1'b0;
      // Configuration churn while busy must not affect the latched run.
      if (busy) begin
        shot_count = SHOT_W'($urandom);
        holdoff_cycles = CNT_W'($urandom_range(0, 100));
        timeout_cycles = CNT_W'($urandom_range(1, 5));
      end
      prev_start = exp_start;
      prev_shots = shots_done;
    end
    n_cmp++;
    if ({done_cnt, pulses} !== {1, sc}) begin
      n_fail++;
      $display("[TB] FAIL run_totals: done pulses %0d, start pulses %0d expected 1, %0d", done_cnt, pulses, sc);
    end
    n_cmp++;
    if ({shots_done, error, busy} !== {SHOT_W'(sc), 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL run_end: shots/error/busy got %0d/%b/%b expected %0d/0/0", shots_done, error, busy, sc);
    end
    exp_detonation = 1'b0;
    exp_trigger = 1'b0;
    arm = 1'b0;
    tick();
  endtask

  task automatic test_basic_run();
    run_scenario(3, 10, 0, 0);
  endtask

  task automatic test_early_detonation();
    run_scenario(1, 0, 0, 1);
    run_scenario(2, 3, 40, 1);
  endtask

  task automatic test_random_runs(input int n);
    for (int r = 0; r < n; r++)
      run_scenario(int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(20, 60)), 2);
  endtask

  task automatic test_ready_timeout();
    int  cnt;
    bit  started;
    cnt = 0;
    started = 1'b0;
    detector_ready = 1'b0;
    repeat (3) tick();
    shot_count = 8'd2;
    holdoff_cycles = '0;
    timeout_cycles = 32'd50;
    arm = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (exp_start) started = 1'b1;
      if (error) break;
      if (busy) cnt++;
    end
    n_cmp++;
    if (cnt !== 50) begin
      n_fail++;
      $display("[TB] FAIL ready_timeout_cycles: got %0d expected 50", cnt);
    end
    n_cmp++;
    if ({error, error_code, busy, started} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL ready_timeout_state: err/code/busy/start got %b/%0d/%b/%b expected 1/1/0/0",
               error, error_code, busy, started);
    end
    arm = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({error, error_code} !== {1'b1, 3'd1}) begin
      n_fail++;
      $display("[TB] FAIL error_hold: err/code got %b/%0d expected 1/1", error, error_code);
    end
    detector_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_order_violation();
    bit ok1, ok2;
    shot_count = 8'd2;
    holdoff_cycles = '0;
    timeout_cycles = '0;
    arm = 1'b1;
    wait_start(1'b1, ok1);
    wait_start(1'b0, ok2);
    n_cmp++;
    if ({ok1, ok2} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL order_pulse_seen: got %b expected 11", {ok1, ok2});
    end
    exp_trigger = 1'b1;
    tick();
    n_cmp++;
    if ({error, error_code, busy} !== {1'b1, 3'd4, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL order_violation: err/code/busy got %b/%0d/%b expected 1/4/0", error, error_code, busy);
    end
    exp_trigger = 1'b0;
    arm = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_abort();
    bit ok;
    shot_count = 8'd2;
    holdoff_cycles = '0;
    timeout_cycles = '0;
    arm = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_with_arm: busy got %b expected 0", busy);
    end
    arm = 1'b0;
    tick();
    arm = 1'b1;
    wait_start(1'b1, ok);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({ok, exp_start, error, error_code} !== {1'b1, 1'b0, 1'b1, 3'd5}) begin
      n_fail++;
      $display("[TB] FAIL abort_in_start: seen/start/err/code got %b/%b/%b/%0d expected 1/0/1/5",
               ok, exp_start, error, error_code);
    end
    repeat (5) tick();
    n_cmp++;
    if ({busy, error, exp_start} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL fault_hold_arm_high: busy/err/start got %b expected 010", {busy, error, exp_start});
    end
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    n_cmp++;
    if ({busy, error, error_code} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("[TB] FAIL rearm_after_fault: busy/err/code got %b/%b/%0d expected 1/0/0", busy, error, error_code);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_zero_shots();
    int done_cnt;
    bit busy_seen, start_seen;
    done_cnt = 0;
    busy_seen = 1'b0;
    start_seen = 1'b0;
    shot_count = '0;
    arm = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (exp_start) start_seen = 1'b1;
    end
    n_cmp++;
    if ({done_cnt, busy_seen, start_seen} !== {1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL zero_shots_flow: done/busy/start got %0d/%b/%b expected 1/0/0", done_cnt, busy_seen, start_seen);
    end
    n_cmp++;
    if ({shots_done, error} !== {SHOT_W'(0), 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL zero_shots_count: shots/err got %0d/%b expected 0/0", shots_done, error);
    end
    arm = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [14:0] outs;
    shot_count = 8'd2;
    holdoff_cycles = '0;
    timeout_cycles = '0;
    arm = 1'b1;
    wait_start(1'b1, ok);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({ok, exp_start, busy} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL reset_in_start: seen/start/busy got %b expected 100", {ok, exp_start, busy});
    end
    @(negedge clock) reset = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL no_restart_after_reset: busy got %b expected 0", busy);
    end
    arm = 1'b0;
    tick();
    arm = 1'b1;
    wait_start(1'b1, ok);
    wait_start(1'b0, ok);
    exp_detonation = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({ok, busy} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL reach_wait_trig: seen/busy got %b expected 11", {ok, busy});
    end
    #2 reset = 1'b0;
    #1;
    outs = {exp_start, busy, done, error, error_code, shots_done};
    n_cmp++;
    if (outs !== 15'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_wait_trig: got %h expected 0", outs);
    end
    exp_detonation = 1'b0;
    arm = 1'b0;
    @(negedge clock) reset = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_early_detonation();
    test_ready_timeout();
    test_order_violation();
    test_abort();
    test_random_runs(8);
    test_zero_shots();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
